mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage between `execute` and register writeback. Takes the `execute` result (ALU value or effective address), the store operand and the load/store controls. Runs a request/grant/response transaction on the data-memory port for loads and stores. Returns a single-cycle writeback pulse carrying the final value, either the aligned and extended load data or the unchanged `execute` result.

## Interface
Parameters:
- `ADDR_W`, 32, data-memory address width; res_i[ADDR_W-1:0] is the address

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `valid_i`  in  1  `execute` outputs valid this cycle
- `ready_o`  out  1  stage accepts valid_i; high only in IDLE
- `res_i`  in  32  `execute` result / effective address
- `rs2_i`  in  32  store data
- `rd_i`  in  5  destination register
- `funct3`  in  3  access size/sign
- `load`, `store`  in  1 each  access type
- `valid_o`  out  1  one-cycle writeback pulse
- `wb_data_o`  out  32  writeback value
- `rd_o`  out  5  destination for writeback
- `err_o`  out  1  access fault, qualified by valid_o
- `mem_req_o`  out  1  bus request
- `mem_we_o`  out  1  1 = write
- `mem_addr_o`  out  ADDR_W  word-aligned address, bits [1:0] = 0
- `mem_be_o`  out  4  byte enables
- `mem_wdata_o`  out  32  lane-shifted store data
- `mem_gnt_i`  in  1  request accepted this cycle
- `mem_rvalid_i`  in  1  read data valid
- `mem_rdata_i`  in  32  read data

## Operation
- States: IDLE, REQ, RESP, DONE.
- IDLE, valid_i=1, load=store=0: capture res_i and rd_i, go to DONE.
- IDLE, valid_i=1, exactly one of load/store set, access legal:
  - Register address, be, wdata and we, go to REQ.
- Fault condition, with no bus request issued; go to DONE with err_o=1 and wb_data_o=0:
  - load and store both set
  - funct3 not in {000,001,010,100,101} for a load, or not in {000,001,010} for a store
  - halfword with addr[0]=1
  - word with addr[1:0]≠0
- REQ: mem_req_o=1; request fields held stable until mem_gnt_i.
  - Grant on a store: go to DONE.
  - Grant on a load: go to RESP.
- RESP: wait for mem_rvalid_i, then register the extracted data and go to DONE.
- DONE: valid_o=1 for exactly one cycle, then IDLE.
- Byte enables by offset o=addr[1:0]:
  - B: 1<<o
  - H: 0011 when o=0, 1100 when o=2
  - W: 1111
- Store data: the byte/halfword is replicated across all lanes (rs2[7:0]×4 or rs2[15:0]×2); mem_be_o selects the lane.
- Load extraction: select the byte/halfword at offset o.
  - funct3 000/001 sign-extend.
  - funct3 100/101 zero-extend.
  - Word passes through.
- mem_rvalid_i outside RESP is ignored.
- mem_gnt_i outside REQ is ignored.
- valid_i outside IDLE is not accepted; ready_o=0.

## Timing
- Reset values: state=IDLE, ready_o=1; all other outputs 0, including mem_req_o, valid_o and err_o.
- Non-memory or fault: accept at T, valid_o at T+1.
- Store, grant at first request cycle: accept T, req T+1, valid_o T+2.
- Load, grant T+1, rvalid T+2: valid_o T+3.
- Each wait cycle on grant or rvalid adds one cycle.
- mem_rvalid_i arrives no earlier than the cycle after mem_gnt_i. At most one transaction is outstanding.
- Reset asserted mid-transaction: immediately drop mem_req_o, return to IDLE, produce no valid_o. A late rvalid after reset is ignored.
- wb_data_o, rd_o and err_o hold their values between pulses. Consumers sample them only with valid_o.

## Structure
- `bamboo_pkg` holds:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101
  - mem_stage state enum
- Sub-module `lsu_align` (combinational):
  - inputs funct3, addr[1:0], rs2, rdata
  - outputs be, wdata, load data, misaligned flag
  - instantiated once.

## Test plan
- ALU passthrough: res_i=0x1234_5678, rd_i=5, load=store=0 -> next cycle valid_o=1, wb_data_o=0x1234_5678, rd_o=5, err_o=0, mem_req_o never high.
- SB: addr 0x103, rs2=0xAB, gnt immediate -> mem_addr_o=0x100, be=1000, wdata=0xABABABAB, we=1; valid_o two cycles after accept.
- LB sign/LBU zero: addr 0x202, rdata=0x0080_0000 -> LB gives 0xFFFF_FF80, LBU gives 0x0000_0080.
- LH at addr 0x301 -> err_o=1, wb_data_o=0, no mem_req_o, valid_o next cycle.
- LW with gnt delayed 3 cycles and rvalid delayed 2 cycles, rdata=0xDEADBEEF:
  - Request fields stay stable throughout REQ.
  - wb_data_o=0xDEADBEEF, valid_o one cycle after rvalid.
  - ready_o=0 throughout.
- rst_n low during RESP -> mem_req_o=0 and state IDLE immediately; subsequent rvalid produces no valid_o.

Source files
------------

// File: rtl/bamboo_pkg.sv
// Shared definitions for the bamboo memory stage: access-size codes,
// stage state encoding and funct3 legality helper.
package bamboo_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_RESP,
      ST_DONE
   } mem_state_e;

   // Stores only have signed-size encodings; loads also allow the unsigned ones.
   function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = !is_store;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and replicated store data for
// requests, byte/halfword extraction with extension for load responses.
module lsu_align
   import bamboo_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] rs2,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic [31:0] ldata,
   output logic        misaligned
);

   logic [31:0] shifted;

   assign shifted = rdata >> {off, 3'b000};

   always_comb begin
      be         = '0;
      wdata      = rs2;
      misaligned = 1'b0;
      case (funct3[1:0])
         2'b00: begin
            be    = 4'b0001 << off;
            wdata = {4{rs2[7:0]}};
         end
         2'b01: begin
            be         = off[1] ? 4'b1100 : 4'b0011;
            wdata      = {2{rs2[15:0]}};
            misaligned = off[0];
         end
         2'b10: begin
            be         = 4'b1111;
            misaligned = (off != 2'b00);
         end
         default: ;
      endcase
   end

   always_comb begin
      ldata = rdata;
      case (funct3)
         F3_B:    ldata = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   ldata = {24'h0, shifted[7:0]};
         F3_H:    ldata = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   ldata = {16'h0, shifted[15:0]};
         default: ldata = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: runs one request/grant/response data-memory
// transaction per load/store and emits a single-cycle writeback pulse.
module mem_stage #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [31:0]       res_i,
   input  logic [31:0]       rs2_i,
   input  logic [4:0]        rd_i,
   input  logic [2:0]        funct3,
   input  logic              load,
   input  logic              store,
   output logic              valid_o,
   output logic [31:0]       wb_data_o,
   output logic [4:0]        rd_o,
   output logic              err_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_be_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [31:0]       mem_rdata_i
);

   import bamboo_pkg::*;

   mem_state_e state_q, state_d;

   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;
   logic              we_q;
   logic [2:0]        f3_q;
   logic [1:0]        off_q;
   logic [4:0]        rd_q;
   logic [31:0]       res_q;

   logic        idle;
   logic        access;
   logic        fault;
   logic [2:0]  al_f3;
   logic [1:0]  al_off;
   logic [3:0]  al_be;
   logic [31:0] al_wdata;
   logic [31:0] al_ldata;
   logic        al_mis;

   assign idle = (state_q == ST_IDLE);

   // One aligner serves both directions: request fields come from the live
   // inputs in IDLE, load extraction uses the captured size/offset afterwards.
   assign al_f3  = idle ? funct3 : f3_q;
   assign al_off = idle ? res_i[1:0] : off_q;

   lsu_align u_align (
      .funct3     (al_f3),
      .off        (al_off),
      .rs2        (rs2_i),
      .rdata      (mem_rdata_i),
      .be         (al_be),
      .wdata      (al_wdata),
      .ldata      (al_ldata),
      .misaligned (al_mis)
   );

   assign access = load ^ store;
   assign fault  = (load & store) | (access & (!f3_legal(funct3, store) | al_mis));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (valid_i) state_d = (access && !fault) ? ST_REQ : ST_DONE;
         end
         ST_REQ: begin
            if (mem_gnt_i) state_d = we_q ? ST_DONE : ST_RESP;
         end
         ST_RESP: begin
            if (mem_rvalid_i) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         f3_q    <= '0;
         off_q   <= '0;
         rd_q    <= '0;
         res_q   <= '0;
      end else if (idle && valid_i) begin
         addr_q  <= {res_i[ADDR_W-1:2], 2'b00};
         be_q    <= al_be;
         wdata_q <= al_wdata;
         we_q    <= store;
         f3_q    <= funct3;
         off_q   <= res_i[1:0];
         rd_q    <= rd_i;
         res_q   <= res_i;
      end
   end

   // Writeback registers change only on entry to DONE so they hold between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_data_o <= '0;
         rd_o      <= '0;
         err_o     <= 1'b0;
      end else if (state_d == ST_DONE && state_q != ST_DONE) begin
         case (state_q)
            ST_IDLE: begin
               wb_data_o <= fault ? 32'h0 : res_i;
               rd_o      <= rd_i;
               err_o     <= fault;
            end
            ST_REQ: begin
               wb_data_o <= res_q;
               rd_o      <= rd_q;
               err_o     <= 1'b0;
            end
            default: begin
               wb_data_o <= al_ldata;
               rd_o      <= rd_q;
               err_o     <= 1'b0;
            end
         endcase
      end
   end

   assign ready_o     = idle;
   assign valid_o     = (state_q == ST_DONE);
   assign mem_req_o   = (state_q == ST_REQ);
   assign mem_we_o    = mem_req_o & we_q;
   assign mem_addr_o  = mem_req_o ? addr_q : '0;
   assign mem_be_o    = mem_req_o ? be_q : '0;
   assign mem_wdata_o = mem_req_o ? wdata_q : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with hand-computed expectations.
module tb_mem_stage;

   localparam int unsigned ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              valid_i;
   logic              ready_o;
   logic [31:0]       res_i;
   logic [31:0]       rs2_i;
   logic [4:0]        rd_i;
   logic [2:0]        funct3;
   logic              load;
   logic              store;
   logic              valid_o;
   logic [31:0]       wb_data_o;
   logic [4:0]        rd_o;
   logic              err_o;
   logic              mem_req_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [3:0]        mem_be_o;
   logic [31:0]       mem_wdata_o;
   logic              mem_gnt_i;
   logic              mem_rvalid_i;
   logic [31:0]       mem_rdata_i;

   int checks = 0;
   int errors = 0;

   mem_stage #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .res_i        (res_i),
      .rs2_i        (rs2_i),
      .rd_i         (rd_i),
      .funct3       (funct3),
      .load         (load),
      .store        (store),
      .valid_o      (valid_o),
      .wb_data_o    (wb_data_o),
      .rd_o         (rd_o),
      .err_o        (err_o),
      .mem_req_o    (mem_req_o),
      .mem_we_o     (mem_we_o),
      .mem_addr_o   (mem_addr_o),
      .mem_be_o     (mem_be_o),
      .mem_wdata_o  (mem_wdata_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents one operation in IDLE and returns at the negedge following the accepting edge.
   task automatic accept(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd);
      valid_i = 1'b1; load = ld; store = st; funct3 = f3;
      res_i = addr; rs2_i = rs2; rd_i = rd;
      chk("ready_before_accept", ready_o, 1);
      @(negedge clk);
      valid_i = 1'b0; load = 1'b0; store = 1'b0;
      res_i = 32'h5A5A_5A5A; rs2_i = 32'hC3C3_C3C3; rd_i = 5'd0;
   endtask

   task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rs2, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
      accept(1'b0, 1'b1, f3, addr, rs2, 5'd0);
      mem_gnt_i = 1'b1;
      chk({tag, "_req"},   mem_req_o, 1);
      chk({tag, "_we"},    mem_we_o, 1);
      chk({tag, "_addr"},  mem_addr_o, exp_addr);
      chk({tag, "_be"},    mem_be_o, exp_be);
      chk({tag, "_wdata"}, mem_wdata_o, exp_wdata);
      chk({tag, "_novalid"}, valid_o, 0);
      @(negedge clk);
      mem_gnt_i = 1'b0;
      chk({tag, "_valid"}, valid_o, 1);
      chk({tag, "_err"},   err_o, 0);
      chk({tag, "_req_off"}, mem_req_o, 0);
      @(negedge clk);
      chk({tag, "_pulse_end"}, valid_o, 0);
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input int gnt_wait, input int rv_wait,
                          input logic [31:0] rdata, input logic [31:0] exp_wb);
      accept(1'b1, 1'b0, f3, addr, 32'hFFFF_FFFF, 5'd7);
      for (int i = 0; i < gnt_wait; i++) begin
         chk({tag, "_wait_req"},  mem_req_o, 1);
         chk({tag, "_wait_addr"}, mem_addr_o, exp_addr);
         chk({tag, "_wait_be"},   mem_be_o, exp_be);
         chk({tag, "_wait_we"},   mem_we_o, 0);
         chk({tag, "_wait_rdy"},  ready_o, 0);
         @(negedge clk);
      end
      mem_gnt_i = 1'b1;
      chk({tag, "_req"},  mem_req_o, 1);
      chk({tag, "_addr"}, mem_addr_o, exp_addr);
      chk({tag, "_be"},   mem_be_o, exp_be);
      chk({tag, "_we"},   mem_we_o, 0);
      @(negedge clk);
      mem_gnt_i = 1'b0;
      for (int i = 0; i < rv_wait; i++) begin
         chk({tag, "_resp_req"},   mem_req_o, 0);
         chk({tag, "_resp_valid"}, valid_o, 0);
         chk({tag, "_resp_rdy"},   ready_o, 0);
         @(negedge clk);
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rdata;
      chk({tag, "_rv_novalid"}, valid_o, 0);
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h1357_9BDF;
      chk({tag, "_valid"}, valid_o, 1);
      chk({tag, "_wb"},    wb_data_o, exp_wb);
      chk({tag, "_rd"},    rd_o, 7);
      chk({tag, "_err"},   err_o, 0);
      @(negedge clk);
      chk({tag, "_pulse_end"}, valid_o, 0);
      chk({tag, "_wb_hold"},   wb_data_o, exp_wb);
   endtask

   task automatic do_fault(input string tag, input logic ld, input logic st,
                           input logic [2:0] f3, input logic [31:0] addr);
      accept(ld, st, f3, addr, 32'h1111_2222, 5'd9);
      chk({tag, "_valid"}, valid_o, 1);
      chk({tag, "_err"},   err_o, 1);
      chk({tag, "_wb"},    wb_data_o, 0);
      chk({tag, "_rd"},    rd_o, 9);
      chk({tag, "_noreq"}, mem_req_o, 0);
      @(negedge clk);
      chk({tag, "_pulse_end"}, valid_o, 0);
      chk({tag, "_noreq2"},    mem_req_o, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      valid_i = 1'b0; load = 1'b0; store = 1'b0; funct3 = 3'b000;
      res_i = '0; rs2_i = '0; rd_i = '0;
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", ready_o, 1);
      chk("rst_valid", valid_o, 0);
      chk("rst_req",   mem_req_o, 0);
      chk("rst_err",   err_o, 0);
      chk("rst_wb",    wb_data_o, 0);
      chk("rst_rd",    rd_o, 0);
      chk("rst_addr",  mem_addr_o, 0);
      rst_n = 1'b1;

      // ALU passthrough
      accept(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd5);
      chk("alu_valid", valid_o, 1);
      chk("alu_wb",    wb_data_o, 32'h1234_5678);
      chk("alu_rd",    rd_o, 5);
      chk("alu_err",   err_o, 0);
      chk("alu_noreq", mem_req_o, 0);
      chk("alu_busy",  ready_o, 0);
      @(negedge clk);
      chk("alu_pulse_end", valid_o, 0);
      chk("alu_noreq2",    mem_req_o, 0);
      chk("alu_ready",     ready_o, 1);

      do_store("sb",  3'b000, 32'h0000_0103, 32'h0000_00AB, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB);
      do_store("sh",  3'b001, 32'h0000_0302, 32'h1234_BEEF, 32'h0000_0300, 4'b1100, 32'hBEEF_BEEF);
      do_store("sw",  3'b010, 32'h0000_0404, 32'hCAFE_F00D, 32'h0000_0404, 4'b1111, 32'hCAFE_F00D);

      do_load("lb",  3'b000, 32'h0000_0202, 32'h0000_0200, 4'b0100, 0, 0, 32'h0080_0000, 32'hFFFF_FF80);
      do_load("lbu", 3'b100, 32'h0000_0202, 32'h0000_0200, 4'b0100, 0, 0, 32'h0080_0000, 32'h0000_0080);
      do_load("lb1", 3'b000, 32'h0000_0201, 32'h0000_0200, 4'b0010, 0, 0, 32'h0000_7F00, 32'h0000_007F);
      do_load("lh",  3'b001, 32'h0000_0402, 32'h0000_0400, 4'b1100, 1, 0, 32'h8001_0000, 32'hFFFF_8001);
      do_load("lhu", 3'b101, 32'h0000_0402, 32'h0000_0400, 4'b1100, 0, 1, 32'h8001_0000, 32'h0000_8001);
      do_load("lw",  3'b010, 32'h0000_0500, 32'h0000_0500, 4'b1111, 3, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

      do_fault("lh_mis",   1'b1, 1'b0, 3'b001, 32'h0000_0301);
      do_fault("lw_mis",   1'b1, 1'b0, 3'b010, 32'h0000_0202);
      do_fault("sbu_ill",  1'b0, 1'b1, 3'b100, 32'h0000_0200);
      do_fault("l011_ill", 1'b1, 1'b0, 3'b011, 32'h0000_0200);
      do_fault("ld_st",    1'b1, 1'b1, 3'b010, 32'h0000_0200);

      // Reset while waiting for the read response
      accept(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd3);
      mem_gnt_i = 1'b1;
      chk("rr_req", mem_req_o, 1);
      @(negedge clk);
      mem_gnt_i = 1'b0;
      chk("rr_in_resp", ready_o, 0);
      rst_n = 1'b0;
      #1;
      chk("rr_req_drop", mem_req_o, 0);
      chk("rr_idle",     ready_o, 1);
      chk("rr_novalid",  valid_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hBAD0_BAD0;
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      chk("rr_late_rv_valid", valid_o, 0);
      chk("rr_late_rv_ready", ready_o, 1);
      @(negedge clk);
      chk("rr_late_rv_valid2", valid_o, 0);
      chk("rr_wb_untouched",   wb_data_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
